axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM word-address width (2^ADDR_W 32-bit words).
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 arid/araddr/arlen/arvalid  in  4/32/8/1  read address channel; arlen[7:4] ignored.
REQ-005 arready  out  1  read address accepted.
REQ-006 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel.
REQ-007 rready  in  1  master accepts read beat.
REQ-008 awid/awaddr/awlen/awvalid  in  4/32/8/1  write address channel; awlen[7:4] ignored.
REQ-009 awready  out  1  write address accepted.
REQ-010 wdata/wstrb/wlast/wvalid  in  32/4/1/1  write data channel.
REQ-011 wready  out  1  write beat accepted.
REQ-012 bid/bresp/bvalid  out  4/2/1  write response channel.
REQ-013 bready  in  1  master accepts response.
REQ-014 sram_en/sram_we/sram_addr/sram_wdata  out  1/4/ADDR_W/32  SRAM strobe, byte enables, word address, write data.
REQ-015 sram_rdata  in  32  SRAM read data, valid exactly one cycle after sram_en with sram_we=0.

Function
REQ-016 FSM states SHALL be IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP; one transaction in flight at a time.
REQ-017 IDLE: arready = arvalid && (!awvalid || prio_rd); awready = awvalid && (!arvalid || !prio_rd); both 0 outside IDLE.
REQ-018 prio_rd SHALL toggle only when both valids are high in IDLE, after the granted handshake (round-robin).
REQ-019 AR handshake at cycle T: latch id, addr, len; RD_REQ at T+1 drives sram_en=1, sram_we=0; RD_RESP from T+2 with rvalid=1, rdata registered and held stable until rready.
REQ-020 rlast=1 on beat len; after the handshake of a non-last beat, return to RD_REQ with address +4; after the last, return to IDLE.
REQ-021 AW handshake: enter WR_DATA with wready=1; each W handshake drives sram_en=1, sram_we=wstrb, sram_wdata=wdata in the same cycle; address +4 per beat.
REQ-022 The W beat with wlast=1 SHALL move to WR_RESP; bvalid=1 and bid=latched id, held until bready, then IDLE.
REQ-023 Beat word address = addr[ADDR_W+1:2]; addr bits [1:0] and ar/awsize ignored; all beats 32 bits wide.
REQ-024 Any beat whose full 32-bit address has nonzero bits [31:ADDR_W+2] SHALL be DECERR (2'b11): reads return rdata=0 with no sram_en; writes suppress sram_en; bresp is DECERR if any beat erred, else OKAY.
REQ-025 rresp is per beat; OKAY=2'b00.

Reset
REQ-026 resetn low: state IDLE, prio_rd=1, every output 0 (including rid/rdata/bid), regardless of any transaction in flight.
REQ-027 A transaction aborted by reset SHALL receive no response; the next transaction after reset starts cleanly.

Configuration
REQ-028 With AXI_SLAVE_BURST_EN defined: INCR bursts of len+1 beats (1..16) per REQ-019..022.
REQ-029 Without it: len is treated as 0 for SRAM access; a read with len≠0 returns len+1 beats with rresp=SLVERR (2'b10), rdata=0, and no sram_en; a write with len≠0 accepts beats until wlast with no sram_en, and bresp=SLVERR.

Structure
REQ-030 Shared package axi_pkg SHALL hold resp codes (OKAY/SLVERR/DECERR) and the FSM state enum; no sub-module; the memory array is external on the sram_* port.

Verification
REQ-031 Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10 -> bresp=OKAY, rdata=0xDEADBEEF, rlast=1, rvalid at AR+2.
REQ-032 wstrb=4'b0011 with wdata=0x11223344 over 0xDEADBEEF -> read returns 0xDEAD3344.
REQ-033 BURST_EN: read arlen=3 at 0x100 with rready toggling 1/0 -> 4 beats from 0x100..0x10C, data stable while stalled, rlast on beat 3 only.
REQ-034 arvalid and awvalid high together twice in a row -> read granted first, then write; the next conflict is granted to the read.
REQ-035 araddr=0x8000_0000 (ADDR_W=16) -> rresp=DECERR, rdata=0, no sram_en; resetn low during RD_RESP -> rvalid=0 immediately, IDLE afterwards.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response codes and
// the transaction FSM state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_DATA,
    WR_RESP
  } state_e;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       last;
    logic [31:0] data;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging one transaction at a time onto an external SRAM.
// Ports: clk, resetn (async, active low); AR/R, AW/W/B AXI channels
// (4-bit ids, 32-bit data, len[3:0] used); sram_en/we/addr/wdata out,
// sram_rdata in (one-cycle read latency).
// Build option: define AXI_SLAVE_BURST_EN for INCR bursts of 1..16 beats;
// otherwise any len != 0 is answered with SLVERR and no SRAM access.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        fresh_q, fresh_d;

  logic        len_err;
  logic        dec_err;
  logic [1:0]  beat_resp;
  logic        beat_ok;
  logic        unused;

  assign unused = ^{arlen[7:4], awlen[7:4]};

`ifdef AXI_SLAVE_BURST_EN
  assign len_err = 1'b0;
`else
  assign len_err = (len_q != 4'd0);
`endif

  assign dec_err   = |addr_q[31:ADDR_W+2];
  assign beat_resp = dec_err ? RESP_DECERR :
                     len_err ? RESP_SLVERR : RESP_OKAY;
  assign beat_ok   = (beat_resp == RESP_OKAY);

  assign rid       = id_q;
  assign bid       = id_q;
  assign rresp     = rresp_q;
  assign bresp     = bresp_q;
  assign sram_addr = addr_q[ADDR_W+1:2];
  assign rlast     = (state_q == RD_RESP) && (beat_q == len_q);

  // First response cycle forwards the SRAM output; it is captured
  // into rdata_q and held from then on while the master stalls.
  assign rdata = (state_q == RD_RESP && fresh_q) ? sram_rdata : rdata_q;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    bresp_d    = bresp_q;
    fresh_d    = fresh_q;
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    rvalid     = 1'b0;
    bvalid     = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'b0;
    sram_wdata = 32'b0;
    unique case (state_q)
      IDLE: begin
        arready = resetn && arvalid && (!awvalid || prio_q);
        awready = resetn && awvalid && (!arvalid || !prio_q);
        if (arvalid && awvalid) prio_d = !prio_q;
        if (arready) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen[3:0];
          beat_d  = 4'd0;
          state_d = RD_REQ;
        end else if (awready) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen[3:0];
          beat_d  = 4'd0;
          bresp_d = RESP_OKAY;
          state_d = WR_DATA;
        end
      end
      RD_REQ: begin
        sram_en = beat_ok;
        rresp_d = beat_resp;
        fresh_d = beat_ok;
        rdata_d = 32'b0;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (fresh_q) begin
          rdata_d = sram_rdata;
          fresh_d = 1'b0;
        end
        if (rready) begin
          if (rlast) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            addr_d  = addr_q + 32'd4;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_en    = beat_ok;
          sram_we    = beat_ok ? wstrb : 4'b0;
          sram_wdata = wdata;
          addr_d     = addr_q + 32'd4;
          // Codes order as OKAY < SLVERR < DECERR: keep the worst.
          if (beat_resp > bresp_q) bresp_d = beat_resp;
          if (wlast) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      prio_q  <= 1'b1;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      len_q   <= 4'd0;
      beat_q  <= 4'd0;
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
      fresh_q <= fresh_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table, scoreboard
// queues for R/B responses, and hand-written arbitration/reset sequences.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic resetn;
  logic [3:0] arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata, sram_wdata;
  logic [31:0] sram_rdata;
  logic [7:0] arlen, awlen;
  logic arvalid, arready, rvalid, rready, rlast;
  logic awvalid, awready, wvalid, wready, wlast;
  logic bvalid, bready, sram_en;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb, sram_we;
  logic [ADDR_W-1:0] sram_addr;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int en_cnt = 0;

  always @(posedge clk) begin
    if (sram_en) begin
      en_cnt <= en_cnt + 1;
      if (sram_we == 4'b0) sram_rdata <= mem[sram_addr];
      for (int b = 0; b < 4; b++)
        if (sram_we[b])
          mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  int n_pass = 0;
  int n_tot = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endfunction

  function automatic void fail(string nm, logic [63:0] act);
    n_tot++;
    $display("FAIL %s: got %h want none/in-time", nm, act);
  endfunction

  rbeat_t rq[$];
  bresp_t bq[$];
  logic   stall_q = 1'b0;
  rbeat_t stall_v;

  always @(negedge clk) begin
    rbeat_t re;
    bresp_t be;
    if (!resetn) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q && rvalid)
        chk("r_hold", {rid, rresp, rlast, rdata}, stall_v);
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          fail("r_unexpected", {rid, rresp, rlast, rdata});
        end else begin
          re = rq.pop_front();
          chk("r_beat", {rid, rresp, rlast, rdata}, re);
        end
      end
      stall_q <= rvalid && !rready;
      stall_v <= {rid, rresp, rlast, rdata};
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          fail("b_unexpected", {bid, bresp});
        end else begin
          be = bq.pop_front();
          chk("b_resp", {bid, bresp}, be);
        end
      end
    end
  end

  task automatic wait_arw();
    int n = 0;
    @(negedge clk);
    while (!(arready || awready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(arready || awready)) fail("arw_timeout", n);
  endtask

  task automatic wait_w();
    int n = 0;
    @(negedge clk);
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wready) fail("w_timeout", n);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0)
      fail("drain_timeout", rq.size() + bq.size());
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input bit tog,
                         output int lat);
    int n = 0;
    @(posedge clk);
    #1;
    arid = id; araddr = a; arlen = len; arvalid = 1'b1;
    rready = !tog;
    wait_arw();
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    while (rq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      if (tog) rready = !rready;
      n++;
    end
    if (rq.size() != 0) fail("r_timeout", rq.size());
    rready = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [31:0] base,
                          input logic [3:0] strb);
    @(posedge clk);
    #1;
    awid = id; awaddr = a; awlen = len; awvalid = 1'b1;
    bready = 1'b1;
    wait_arw();
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + i; wstrb = strb;
      wlast = (i == int'(len)); wvalid = 1'b1;
      wait_w();
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    drain();
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  vec_t tv[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, e0;
    tv[0]  = '{1, 4'h1, 32'h10, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY};
    tv[1]  = '{0, 4'h2, 32'h10, 0, 0, 32'hDEADBEEF, RESP_OKAY};
    tv[2]  = '{1, 4'h3, 32'h10, 32'h11223344, 4'h3, 0, RESP_OKAY};
    tv[3]  = '{0, 4'h4, 32'h10, 0, 0, 32'hDEAD3344, RESP_OKAY};
    tv[4]  = '{1, 4'h5, 32'h20, 32'hA5A5A5A5, 4'hF, 0, RESP_OKAY};
    tv[5]  = '{1, 4'h6, 32'h20, 32'h5A000000, 4'h8, 0, RESP_OKAY};
    tv[6]  = '{0, 4'h7, 32'h23, 0, 0, 32'h5AA5A5A5, RESP_OKAY};
    tv[7]  = '{1, 4'h8, 32'h80000000, 32'hCAFEF00D, 4'hF, 0,
               RESP_DECERR};
    tv[8]  = '{0, 4'h9, 32'h80000000, 0, 0, 0, RESP_DECERR};
    tv[9]  = '{1, 4'hA, 32'h3FFFC, 32'h12345678, 4'hF, 0, RESP_OKAY};
    tv[10] = '{0, 4'hB, 32'h3FFFC, 0, 0, 32'h12345678, RESP_OKAY};
    tv[11] = '{0, 4'hC, 32'h40000, 0, 0, 0, RESP_DECERR};
    tv[12] = '{1, 4'hD, 32'h40010, 32'hFFFFFFFF, 4'hF, 0,
               RESP_DECERR};
    tv[13] = '{0, 4'hE, 32'h10, 0, 0, 32'hDEAD3344, RESP_OKAY};

    resetn = 1'b0;
    arid = 0; araddr = 0; arlen = 0; arvalid = 1'b1;
    awid = 0; awaddr = 0; awlen = 0; awvalid = 1'b1;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r", {rid, rdata, rresp, rlast, rvalid, arready,
                  awready, wready}, 0);
    chk("rst_b", {bid, bresp, bvalid, sram_en, sram_we, sram_addr,
                  sram_wdata}, 0);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    resetn = 1'b1;

    foreach (tv[i]) begin
      e0 = en_cnt;
      if (tv[i].wr) begin
        bq.push_back('{tv[i].id, tv[i].resp});
        do_write(tv[i].id, tv[i].addr, 8'd0, tv[i].data, tv[i].strb);
      end else begin
        rq.push_back('{tv[i].id, tv[i].resp, 1'b1, tv[i].exp});
        do_read(tv[i].id, tv[i].addr, 8'd0, 1'b0, lat);
        if (i == 1) chk("rd_latency", lat, 2);
      end
      @(posedge clk);
      #1;
      chk("en_count", en_cnt - e0, (tv[i].resp == RESP_OKAY) ? 1 : 0);
    end

`ifdef AXI_SLAVE_BURST_EN
    e0 = en_cnt;
    bq.push_back('{4'h3, RESP_OKAY});
    do_write(4'h3, 32'h100, 8'd3, 32'hB0000000, 4'hF);
    for (int i = 0; i < 4; i++)
      rq.push_back('{4'h4, RESP_OKAY, i == 3, 32'hB0000000 + i});
    do_read(4'h4, 32'h100, 8'hF3, 1'b1, lat);
    @(posedge clk);
    #1;
    chk("burst_en_count", en_cnt - e0, 8);
`else
    e0 = en_cnt;
    for (int i = 0; i < 4; i++)
      rq.push_back('{4'h1, RESP_SLVERR, i == 3, 32'h0});
    do_read(4'h1, 32'h10, 8'h13, 1'b1, lat);
    bq.push_back('{4'h2, RESP_SLVERR});
    do_write(4'h2, 32'h10, 8'd1, 32'h99999999, 4'hF);
    @(posedge clk);
    #1;
    chk("slverr_en_count", en_cnt - e0, 0);
    rq.push_back('{4'h3, RESP_OKAY, 1'b1, 32'hDEAD3344});
    do_read(4'h3, 32'h10, 8'd0, 1'b0, lat);
`endif

    rready = 1'b1; bready = 1'b1;
    @(posedge clk);
    #1;
    rq.push_back('{4'h6, RESP_OKAY, 1'b1, 32'h5AA5A5A5});
    arid = 4'h6; araddr = 32'h20; arlen = 0; arvalid = 1'b1;
    awid = 4'h7; awaddr = 32'h40; awlen = 0; awvalid = 1'b1;
    wait_arw();
    chk("arb1", {arready, awready}, 2'b10);
    @(posedge clk);
    #1;
    rq.push_back('{4'h8, RESP_OKAY, 1'b1, 32'h12345678});
    arid = 4'h8; araddr = 32'h3FFFC;
    wait_arw();
    chk("arb2", {arready, awready}, 2'b01);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    bq.push_back('{4'h7, RESP_OKAY});
    wdata = 32'h11111111; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    wait_w();
    @(posedge clk);
    #1;
    wvalid = 1'b0; wlast = 1'b0;
    bq.push_back('{4'h9, RESP_OKAY});
    awid = 4'h9; awaddr = 32'h44; awvalid = 1'b1;
    wait_arw();
    chk("arb3", {arready, awready}, 2'b10);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    wait_arw();
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wdata = 32'h22222222; wlast = 1'b1; wvalid = 1'b1;
    wait_w();
    @(posedge clk);
    #1;
    wvalid = 1'b0; wlast = 1'b0;
    drain();
    rq.push_back('{4'hA, RESP_OKAY, 1'b1, 32'h11111111});
    do_read(4'hA, 32'h40, 8'd0, 1'b0, lat);
    rq.push_back('{4'hB, RESP_OKAY, 1'b1, 32'h22222222});
    do_read(4'hB, 32'h44, 8'd0, 1'b0, lat);

    @(posedge clk);
    #1;
    arid = 4'h5; araddr = 32'h10; arlen = 0; arvalid = 1'b1;
    rready = 1'b0;
    wait_arw();
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("rv_before_rst", rvalid, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_mid_r", {rid, rdata, rresp, rlast, arready, awready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_after_rst", {rvalid, bvalid, wready}, 0);
    rq.push_back('{4'hC, RESP_OKAY, 1'b1, 32'hDEAD3344});
    do_read(4'hC, 32'h10, 8'd0, 1'b0, lat);
    chk("post_rst_latency", lat, 2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
